// File: rtl/pong_engine.sv
// Pong game engine: paddles, ball, scores, serve countdown and match-win logic,
// advanced once per video frame; pixel flags feed the colour mux.
module pong_engine #(
  parameter int HD            = 640,
  parameter int VD            = 480,
  parameter int PW            = 10,
  parameter int PH            = 100,
  parameter int BD            = 10,
  parameter int LP            = 60,
  parameter int RP            = 570,
  parameter int TOP           = 33,
  parameter int TOPT          = 3,
  parameter int PS            = 2,
  parameter int BS_INIT       = 1,
  parameter int BS_MAX        = 4,
  parameter int HITS_PER_STEP = 4,
  parameter int WIN_SCORE     = 7,
  parameter int PAUSE_FRAMES  = 60,
  parameter int SW            = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          up_left,
  input  logic          dn_left,
  input  logic          up_right,
  input  logic          dn_right,
  input  logic          new_game,
  output logic [SW-1:0] score_left,
  output logic [SW-1:0] score_right,
  output logic [1:0]    countdown,
  output logic          game_over,
  output logic          winner,
  output logic          lp_on,
  output logic          rp_on,
  output logic          ball_on,
  output logic          top_on
);
  typedef logic signed [11:0] pos_t;
  typedef enum logic [2:0] {S3, S2, S1, PLAY, OVER} state_t;

  localparam int PT  = TOP + TOPT;
  localparam int HCW = $clog2(HITS_PER_STEP + 1);
  localparam int FCW = $clog2(PAUSE_FRAMES + 1);

  localparam pos_t C_PT    = pos_t'(PT);
  localparam pos_t C_PBOT  = pos_t'(VD - PH);
  localparam pos_t C_PY0   = pos_t'((VD + PT - PH) / 2);
  localparam pos_t C_BX0   = pos_t'((HD - BD) / 2);
  localparam pos_t C_BY0   = pos_t'((VD + PT - BD) / 2);
  localparam pos_t C_LP    = pos_t'(LP);
  localparam pos_t C_LPF   = pos_t'(LP + PW);
  localparam pos_t C_RP    = pos_t'(RP);
  localparam pos_t C_RPE   = pos_t'(RP + PW);
  localparam pos_t C_PH    = pos_t'(PH);
  localparam pos_t C_BD    = pos_t'(BD);
  localparam pos_t C_HD    = pos_t'(HD);
  localparam pos_t C_VD    = pos_t'(VD);
  localparam pos_t C_PS    = pos_t'(PS);
  localparam pos_t C_TOP   = pos_t'(TOP);
  localparam pos_t C_BS0   = pos_t'(BS_INIT);
  localparam pos_t C_BSMAX = pos_t'(BS_MAX);
  localparam logic signed [23:0] BD_SQ = 24'(BD * BD);
  localparam logic [SW-1:0]  WIN_M1    = SW'(WIN_SCORE - 1);
  localparam logic [HCW-1:0] HIT_LAST  = HCW'(HITS_PER_STEP - 1);
  localparam logic [FCW-1:0] FRM_LAST  = FCW'(PAUSE_FRAMES - 1);

  logic           match, match_q, tick;
  pos_t           lpy_reg, rpy_reg, bx_reg, by_reg, speed_reg;
  logic           dir_right_reg, dir_down_reg;
  logic [HCW-1:0] hit_cnt_reg;
  logic [FCW-1:0] frame_cnt_reg;
  state_t         state_reg;

  pos_t           bx_next, by_next, speed_next;
  logic           dir_right_next, dir_down_next, miss_left, miss_right;
  logic [HCW-1:0] hit_cnt_next;
  logic           hit, lov, rov;

  assign match = (pixel_x == 10'd0) && (pixel_y == 10'(VD));
  assign tick  = match && !match_q;

  function automatic pos_t paddle_next(input pos_t y, input logic up, input logic dn);
    paddle_next = y;
    if (up && !dn)
      paddle_next = (y - C_PS < C_PT) ? C_PT : y - C_PS;
    else if (dn && !up)
      paddle_next = (y + C_PS > C_PBOT) ? C_PBOT : y + C_PS;
  endfunction

  // Ball motion for one PLAY frame, using the paddle positions before this frame's move.
  always_comb begin
    by_next        = by_reg;
    dir_down_next  = dir_down_reg;
    bx_next        = bx_reg;
    dir_right_next = dir_right_reg;
    speed_next     = speed_reg;
    hit_cnt_next   = hit_cnt_reg;
    hit            = 1'b0;
    miss_left      = 1'b0;
    miss_right     = 1'b0;
    lov = (by_reg + C_BD > lpy_reg) && (by_reg < lpy_reg + C_PH);
    rov = (by_reg + C_BD > rpy_reg) && (by_reg < rpy_reg + C_PH);

    if (dir_down_reg) begin
      if (by_reg + C_BD + speed_reg > C_VD) begin
        by_next       = C_VD - C_BD;
        dir_down_next = 1'b0;
      end else begin
        by_next = by_reg + speed_reg;
      end
    end else if (by_reg - speed_reg < C_PT) begin
      by_next       = C_PT;
      dir_down_next = 1'b1;
    end else begin
      by_next = by_reg - speed_reg;
    end

    if (!dir_right_reg) begin
      if (bx_reg >= C_LPF && bx_reg - speed_reg < C_LPF && lov) begin
        bx_next        = C_LPF;
        dir_right_next = 1'b1;
        hit            = 1'b1;
      end else if (bx_reg < speed_reg) begin
        miss_left = 1'b1;
      end else begin
        bx_next = bx_reg - speed_reg;
      end
    end else begin
      if (bx_reg + C_BD <= C_RP && bx_reg + C_BD + speed_reg > C_RP && rov) begin
        bx_next        = C_RP - C_BD;
        dir_right_next = 1'b0;
        hit            = 1'b1;
      end else if (bx_reg + C_BD + speed_reg > C_HD) begin
        miss_right = 1'b1;
      end else begin
        bx_next = bx_reg + speed_reg;
      end
    end

    if (hit) begin
      if (hit_cnt_reg == HIT_LAST) begin
        hit_cnt_next = '0;
        speed_next   = (speed_reg >= C_BSMAX) ? C_BSMAX : speed_reg + 12'sd1;
      end else begin
        hit_cnt_next = hit_cnt_reg + HCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_q       <= 1'b0;
      lpy_reg       <= C_PY0;
      rpy_reg       <= C_PY0;
      bx_reg        <= C_BX0;
      by_reg        <= C_BY0;
      dir_right_reg <= 1'b1;
      dir_down_reg  <= 1'b0;
      speed_reg     <= C_BS0;
      hit_cnt_reg   <= '0;
      frame_cnt_reg <= '0;
      score_left    <= '0;
      score_right   <= '0;
      state_reg     <= S3;
      countdown     <= 2'd3;
      game_over     <= 1'b0;
      winner        <= 1'b0;
    end else begin
      match_q <= match;
      if (tick) begin
        if (state_reg != OVER) begin
          lpy_reg <= paddle_next(lpy_reg, up_left, dn_left);
          rpy_reg <= paddle_next(rpy_reg, up_right, dn_right);
        end
        if (new_game) begin
          bx_reg        <= C_BX0;
          by_reg        <= C_BY0;
          dir_right_reg <= 1'b1;
          dir_down_reg  <= 1'b0;
          speed_reg     <= C_BS0;
          hit_cnt_reg   <= '0;
          frame_cnt_reg <= '0;
          score_left    <= '0;
          score_right   <= '0;
          state_reg     <= S3;
          countdown     <= 2'd3;
          game_over     <= 1'b0;
          winner        <= 1'b0;
        end else begin
          case (state_reg)
            S3, S2, S1: begin
              if (frame_cnt_reg == FRM_LAST) begin
                frame_cnt_reg <= '0;
                countdown     <= countdown - 2'd1;
                state_reg     <= (state_reg == S3) ? S2 : (state_reg == S2) ? S1 : PLAY;
              end else begin
                frame_cnt_reg <= frame_cnt_reg + FCW'(1);
              end
            end
            PLAY: begin
              if (miss_left || miss_right) begin
                bx_reg        <= C_BX0;
                by_reg        <= C_BY0;
                speed_reg     <= C_BS0;
                hit_cnt_reg   <= '0;
                frame_cnt_reg <= '0;
                // Serve toward the player who just lost the point.
                dir_right_reg <= miss_right;
                if (miss_left) score_right <= score_right + SW'(1);
                else           score_left  <= score_left + SW'(1);
                if ((miss_left ? score_right : score_left) == WIN_M1) begin
                  state_reg <= OVER;
                  countdown <= 2'd0;
                  game_over <= 1'b1;
                  winner    <= miss_left;
                end else begin
                  state_reg <= S3;
                  countdown <= 2'd3;
                end
              end else begin
                bx_reg        <= bx_next;
                by_reg        <= by_next;
                dir_right_reg <= dir_right_next;
                dir_down_reg  <= dir_down_next;
                speed_reg     <= speed_next;
                hit_cnt_reg   <= hit_cnt_next;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  pos_t px, py, bdx, bdy, ex, ey;
  logic signed [23:0] ex_w, ey_w;

  always_comb begin
    px   = pos_t'({2'b00, pixel_x});
    py   = pos_t'({2'b00, pixel_y});
    bdx  = px - bx_reg;
    bdy  = py - by_reg;
    ex   = bdx + bdx + 12'sd1 - C_BD;
    ey   = bdy + bdy + 12'sd1 - C_BD;
    ex_w = 24'(ex);
    ey_w = 24'(ey);
    lp_on   = (px >= C_LP) && (px < C_LPF) && (py >= lpy_reg) && (py < lpy_reg + C_PH);
    rp_on   = (px >= C_RP) && (px < C_RPE) && (py >= rpy_reg) && (py < rpy_reg + C_PH);
    top_on  = (py >= C_TOP) && (py < C_PT);
    ball_on = (bdx >= 12'sd0) && (bdx < C_BD) && (bdy >= 12'sd0) && (bdy < C_BD) &&
              (ex_w * ex_w + ey_w * ey_w <= BD_SQ);
  end
endmodule

// File: tb/tb_pong_engine.sv
// Randomised frame-level bench for pong_engine against an integer game model;
// ball/paddle positions are observed through the pixel flags.
module tb_pong_engine;
  localparam int HD = 640, VD = 480, PW = 10, PH = 100, BD = 10, LP = 60, RP = 570;
  localparam int TOP = 33, TOPT = 3, PT = TOP + TOPT, PS = 2;
  localparam int BS_INIT = 1, BS_MAX = 4, HPS = 4, WIN = 3, PF = 2, SW = 4;
  localparam int FRAMES = 2500;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [9:0]    pixel_x = 10'd100, pixel_y = 10'd100;
  logic          up_left = 0, dn_left = 0, up_right = 0, dn_right = 0, new_game = 0;
  logic [SW-1:0] score_left, score_right;
  logic [1:0]    countdown;
  logic          game_over, winner, lp_on, rp_on, ball_on, top_on;

  int n_checks = 0, n_fail = 0;
  // Model: phase 3/2/1 = countdown digit, 0 = rally, -1 = match over.
  int m_lpy, m_rpy, m_bx, m_by, m_dx, m_dy, m_v, m_hits, m_phase, m_cnt;
  int m_sl, m_sr, m_over, m_win;

  pong_engine #(.PAUSE_FRAMES(PF), .WIN_SCORE(WIN)) dut (
    .clk(clk), .reset_n(reset_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .up_left(up_left), .dn_left(dn_left), .up_right(up_right), .dn_right(dn_right),
    .new_game(new_game), .score_left(score_left), .score_right(score_right),
    .countdown(countdown), .game_over(game_over), .winner(winner),
    .lp_on(lp_on), .rp_on(rp_on), .ball_on(ball_on), .top_on(top_on)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pad_move(int y, bit up, bit dn);
    if (up && !dn) return (y - PS < PT) ? PT : y - PS;
    if (dn && !up) return (y + PS > VD - PH) ? VD - PH : y + PS;
    return y;
  endfunction

  task automatic model_restart();
    m_bx = (HD - BD) / 2; m_by = (VD + PT - BD) / 2;
    m_dx = 1; m_dy = -1; m_v = BS_INIT; m_hits = 0; m_cnt = 0;
    m_sl = 0; m_sr = 0; m_phase = 3; m_over = 0; m_win = 0;
  endtask

  task automatic model_point(bit right_scored);
    int s;
    if (right_scored) begin m_sr++; s = m_sr; m_dx = -1; end
    else begin m_sl++; s = m_sl; m_dx = 1; end
    m_bx = (HD - BD) / 2; m_by = (VD + PT - BD) / 2;
    m_v = BS_INIT; m_hits = 0; m_cnt = 0;
    if (s == WIN) begin m_phase = -1; m_over = 1; m_win = right_scored; end
    else m_phase = 3;
  endtask

  task automatic model_tick(bit ul, bit dl, bit ur, bit dr, bit ng);
    int olpy = m_lpy, orpy = m_rpy, nlpy = m_lpy, nrpy = m_rpy;
    int nx, ny, ndy;
    if (m_phase != -1) begin
      nlpy = pad_move(m_lpy, ul, dl);
      nrpy = pad_move(m_rpy, ur, dr);
    end
    if (ng) begin
      model_restart();
    end else if (m_phase > 0) begin
      if (m_cnt == PF - 1) begin m_cnt = 0; m_phase--; end
      else m_cnt++;
    end else if (m_phase == 0) begin
      ny = m_by + m_dy * m_v; ndy = m_dy;
      if (m_dy < 0 && ny < PT) begin ny = PT; ndy = 1; end
      else if (m_dy > 0 && ny + BD > VD) begin ny = VD - BD; ndy = -1; end
      nx = m_bx + m_dx * m_v;
      if (m_dx < 0 && m_bx >= LP + PW && nx < LP + PW && m_by + BD > olpy && m_by < olpy + PH) begin
        m_bx = LP + PW; m_dx = 1; m_by = ny; m_dy = ndy; m_hits++;
      end else if (m_dx > 0 && m_bx + BD <= RP && nx + BD > RP && m_by + BD > orpy && m_by < orpy + PH) begin
        m_bx = RP - BD; m_dx = -1; m_by = ny; m_dy = ndy; m_hits++;
      end else if (m_dx < 0 && nx < 0) begin
        model_point(1'b1);
      end else if (m_dx > 0 && nx + BD > HD) begin
        model_point(1'b0);
      end else begin
        m_bx = nx; m_by = ny; m_dy = ndy;
      end
      if (m_hits == HPS) begin
        m_hits = 0;
        if (m_v < BS_MAX) m_v++;
      end
    end
    m_lpy = nlpy; m_rpy = nrpy;
  endtask

  function automatic bit m_ball(int px, int py);
    int dx = px - m_bx, dy = py - m_by;
    if (dx < 0 || dx >= BD || dy < 0 || dy >= BD) return 1'b0;
    return ((2*dx + 1 - BD) * (2*dx + 1 - BD) + (2*dy + 1 - BD) * (2*dy + 1 - BD)) <= BD * BD;
  endfunction

  task automatic sample(int px_in, int py_in);
    int px = (px_in < 0) ? 0 : px_in;
    int py = (py_in < 0) ? 0 : py_in;
    if (px == 0 && py == VD) py = VD - 1;
    @(negedge clk);
    pixel_x = 10'(px); pixel_y = 10'(py);
    #1;
    check_val("lp_on", lp_on, (px >= LP && px < LP + PW && py >= m_lpy && py < m_lpy + PH));
    check_val("rp_on", rp_on, (px >= RP && px < RP + PW && py >= m_rpy && py < m_rpy + PH));
    check_val("top_on", top_on, (py >= TOP && py < PT));
    check_val("ball_on", ball_on, m_ball(px, py));
  endtask

  task automatic check_state();
    check_val("score_left", score_left, m_sl);
    check_val("score_right", score_right, m_sr);
    check_val("countdown", countdown, (m_phase > 0) ? m_phase : 0);
    check_val("game_over", game_over, m_over);
    check_val("winner", winner, m_win);
  endtask

  task automatic check_frame();
    check_state();
    sample(m_bx + BD / 2, m_by + BD / 2);
    sample(m_bx, m_by);
    sample(m_bx - 3 + $urandom_range(0, BD + 5), m_by - 3 + $urandom_range(0, BD + 5));
    sample(m_bx - 3 + $urandom_range(0, BD + 5), m_by - 3 + $urandom_range(0, BD + 5));
    sample(LP - 2 + $urandom_range(0, PW + 3), m_lpy - 2 + $urandom_range(0, 4) + ($urandom_range(0, 1) ? PH - 2 : 0));
    sample(RP - 2 + $urandom_range(0, PW + 3), m_rpy - 2 + $urandom_range(0, 4) + ($urandom_range(0, 1) ? PH - 2 : 0));
    sample($urandom_range(1, HD - 1), TOP - 3 + $urandom_range(0, TOPT + 5));
  endtask

  task automatic do_frame(bit ul, bit dl, bit ur, bit dr, bit ng, int hold);
    @(negedge clk);
    up_left = ul; dn_left = dl; up_right = ur; dn_right = dr; new_game = ng;
    pixel_x = 10'd0; pixel_y = 10'(VD);
    repeat (hold) @(negedge clk);
    pixel_x = 10'd100; pixel_y = 10'd100;
    @(negedge clk);
    model_tick(ul, dl, ur, dr, ng);
  endtask

  initial begin : main
    int mode, over_frames, tgt, psl, psr;
    bit ul, dl, ur, dr, ng;
    mode = 3; over_frames = 0;
    repeat (3) @(negedge clk);
    m_lpy = (VD + PT - PH) / 2; m_rpy = m_lpy;
    model_restart();
    check_state();
    reset_n = 1'b1;
    check_frame();

    for (int f = 0; f < FRAMES; f++) begin
      if (f % 100 == 0) mode = (f < 100) ? 3 : (f < 200) ? 4 : int'($urandom_range(0, 4));
      tgt = m_by + BD / 2 - PH / 2;
      case (mode)
        0: begin ul = m_lpy > tgt + 1; dl = m_lpy < tgt - 1; ur = m_rpy > tgt + 1; dr = m_rpy < tgt - 1; end
        1: begin ul = 1'($urandom_range(0, 1)); dl = 1'($urandom_range(0, 1));
                 ur = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1)); end
        2: begin ul = m_lpy > tgt + 1; dl = m_lpy < tgt - 1;
                 ur = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1)); end
        3: begin ul = 1; dl = 0; ur = 0; dr = 1; end
        default: begin ul = 1; dl = 1; ur = 1; dr = 1; end
      endcase
      if (m_over != 0) begin
        over_frames++;
        ng = (over_frames >= 4);
      end else begin
        ng = ($urandom_range(0, 599) == 0);
      end
      if (ng) over_frames = 0;
      psl = m_sl; psr = m_sr;
      do_frame(ul, dl, ur, dr, ng, int'($urandom_range(1, 4)));
      if (ng || psl != m_sl || psr != m_sr)
        $display("frame %0d: %s score %0d-%0d countdown=%0d over=%0d winner=%0d",
                 f, ng ? "new game" : "point", m_sl, m_sr, (m_phase > 0) ? m_phase : 0, m_over, m_win);
      check_frame();

      if (f == 1500) begin
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        m_lpy = (VD + PT - PH) / 2; m_rpy = m_lpy;
        model_restart();
        check_state();
        $display("frame %0d: async reset", f);
        @(negedge clk);
        reset_n = 1'b1;
        check_frame();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
